seq_div_4bit: RTL and testbench

Multi-cycle restoring divider paired with the ripple add/subtract datapath: it divides a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, by repeated trial subtraction. It supports signed (two's complement) and unsigned operation, and flags divide-by-zero and signed overflow. It sits beside the adder/subtractor in the arithmetic unit and uses a start/busy/done handshake toward the controlling FSM.

---
 rtl/seq_div_4bit.sv | 193 +++++++++++++++++++
 tb/tb_seq_div_4bit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_div_4bit.sv
// Restoring divider: one quotient bit per clock over sign-stripped magnitudes,
// with a final FIX cycle that restores signs and raises divide-by-zero/overflow flags.
module seq_div_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FIX    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   magb_q, magb_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH:0]   mag_a, mag_b;
  logic [WIDTH+1:0] sh, trial;
  logic             q_neg;
  logic [WIDTH-1:0] q_fix, r_fix, r_low;

  // Sign-extend to WIDTH+1 so the most-negative operand still has a magnitude.
  always_comb begin
    a_neg = sgn & A[WIDTH-1];
    b_neg = sgn & B[WIDTH-1];
    a_ext = {a_neg, A};
    b_ext = {b_neg, B};
    mag_a = a_neg ? (~a_ext + 1'b1) : a_ext;
    mag_b = b_neg ? (~b_ext + 1'b1) : b_ext;
  end

  // Remainder stays below |B| < 2^WIDTH, so sh never sets its top bit and trial's MSB is a true sign.
  always_comb begin
    sh    = {rem_q, dvd_q[WIDTH-1]};
    trial = sh - {1'b0, magb_q};
  end

  always_comb begin
    q_neg = sa_q ^ sb_q;
    q_fix = q_neg ? (~dvd_q + 1'b1) : dvd_q;
    r_low = rem_q[WIDTH-1:0];
    r_fix = sa_q ? (~r_low + 1'b1) : r_low;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dbz_d   = dbz_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    magb_d  = magb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_d  = sgn;
          sa_d   = a_neg;
          sb_d   = b_neg;
          magb_d = mag_b;
          dvd_d  = mag_a[WIDTH-1:0];
          cnt_d  = CW'(WIDTH);
          busy_d = 1'b1;
          if (B == '0) begin
            // Park |A| in the remainder so FIX re-signs it back into A.
            dbz_d   = 1'b1;
            rem_d   = mag_a;
            state_d = S_FIX;
          end else begin
            dbz_d   = 1'b0;
            rem_d   = '0;
            state_d = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = sh[WIDTH:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        r_d     = r_fix;
        dz_d    = dbz_q;
        if (dbz_q) begin
          q_d  = '1;
          ov_d = 1'b0;
        end else begin
          q_d  = q_fix;
          // Signed magnitudes never exceed 2^(WIDTH-1); only a positive 2^(WIDTH-1) fails to fit.
          ov_d = sgn_q & ~q_neg & dvd_q[WIDTH-1];
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dbz_q   <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      magb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dbz_q   <= dbz_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      magb_q  <= magb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_div_4bit.sv
// Directed bench for seq_div_4bit (WIDTH=4) with hand-computed results and latencies.
module tb_seq_div_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sgn;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] R;
  logic       div_by_zero;
  logic       overflow;

  int n_cmp;
  int n_bad;
  int bd_both;
  int lat;
  int done_seen;

  seq_div_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sgn         (sgn),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; returns edges counted until done is seen.
  task automatic wait_done(output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
      if (busy && done) bd_both++;
    end while (!done && l < 20);
  endtask

  task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [3:0] eq, input logic [3:0] er, input logic edz,
                     input logic eov, input int elat);
    int l;
    A = a; B = b; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy"}, 16'(busy), 16'(1));
    wait_done(l);
    chk({tag, ".lat"}, 16'(l), 16'(elat));
    chk({tag, ".Q"}, 16'(Q), 16'(eq));
    chk({tag, ".R"}, 16'(R), 16'(er));
    chk({tag, ".dz"}, 16'(div_by_zero), 16'(edz));
    chk({tag, ".ov"}, 16'(overflow), 16'(eov));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; bd_both = 0; done_seen = 0;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 16'(busy), 16'(0));
    chk("rst.done", 16'(done), 16'(0));
    chk("rst.Q", 16'(Q), 16'(0));
    chk("rst.R", 16'(R), 16'(0));
    chk("rst.flags", 16'({div_by_zero, overflow}), 16'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("u15_4",  4'd15, 4'd4,  1'b0, 4'd3,  4'd3,  1'b0, 1'b0, 5);
    run("s7_2",   4'd7,  4'd2,  1'b1, 4'd3,  4'd1,  1'b0, 1'b0, 5);
    run("sm7_2",  4'h9,  4'd2,  1'b1, 4'hD,  4'hF,  1'b0, 1'b0, 5);
    run("s7_m2",  4'd7,  4'hE,  1'b1, 4'hD,  4'd1,  1'b0, 1'b0, 5);
    run("sm8_3",  4'h8,  4'd3,  1'b1, 4'hE,  4'hE,  1'b0, 1'b0, 5);
    run("ovf",    4'h8,  4'hF,  1'b1, 4'h8,  4'd0,  1'b0, 1'b1, 5);
    run("u8_15",  4'h8,  4'hF,  1'b0, 4'd0,  4'd8,  1'b0, 1'b0, 5);
    run("dbz",    4'd5,  4'd0,  1'b0, 4'hF,  4'd5,  1'b1, 1'b0, 1);
    run("u6_3",   4'd6,  4'd3,  1'b0, 4'd2,  4'd0,  1'b0, 1'b0, 5);
    run("sm8_0",  4'h8,  4'd0,  1'b1, 4'hF,  4'h8,  1'b1, 1'b0, 1);

    // start held through busy while operands toggle: 13/5 unsigned must win.
    A = 4'd13; B = 4'd5; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    do begin
      A = A + 4'd3; B = B ^ 4'b0110; sgn = ~sgn;
      @(posedge clk);
      #1;
      lat++;
      if (busy && done) bd_both++;
    end while (!done && lat < 20);
    start = 1'b0;
    chk("hold.lat", 16'(lat), 16'(5));
    chk("hold.Q", 16'(Q), 16'(2));
    chk("hold.R", 16'(R), 16'(3));

    // Drain whatever the held start launched on the done cycle.
    wait_done(lat);
    @(posedge clk);
    #1;

    // Back-to-back: 9/2 then 14/3 issued during the done cycle.
    A = 4'd9; B = 4'd2; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("b2b1.Q", 16'(Q), 16'(4));
    chk("b2b1.R", 16'(R), 16'(1));
    A = 4'd14; B = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b2.busy", 16'(busy), 16'(1));
    wait_done(lat);
    chk("b2b2.lat", 16'(lat), 16'(5));
    chk("b2b2.Q", 16'(Q), 16'(4));
    chk("b2b2.R", 16'(R), 16'(2));

    // Reset three cycles into a division: outputs clear and no done follows.
    A = 4'd15; B = 4'd4; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.busy", 16'(busy), 16'(0));
    chk("abort.done", 16'(done), 16'(0));
    chk("abort.Q", 16'(Q), 16'(0));
    chk("abort.R", 16'(R), 16'(0));
    chk("abort.flags", 16'({div_by_zero, overflow}), 16'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("abort.nodone", 16'(done_seen), 16'(0));
    chk("busy_done_overlap", 16'(bd_both), 16'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
